// File: rtl/vpu_writeback_if.sv
// UB write port of the VPU writeback block: one assembled row per ready/valid handshake.
interface vpu_writeback_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned ADDR_W = 16
);
    logic               ub_wr_valid;
    logic               ub_wr_ready;
    logic [ADDR_W-1:0]  ub_wr_addr;
    logic [N-1:0][15:0] ub_wr_data;

    modport master (
        output ub_wr_valid,
        output ub_wr_addr,
        output ub_wr_data,
        input  ub_wr_ready
    );

    modport slave (
        input  ub_wr_valid,
        input  ub_wr_addr,
        input  ub_wr_data,
        output ub_wr_ready
    );
endinterface

// File: rtl/vpu_writeback.sv
// De-skews the N-lane VPU result stream into aligned rows and writes them to the UB.
// Optional VPU_WRITEBACK_CHECKSUM_EN adds wb_checksum, the wrapping sum of all written elements.
module vpu_writeback #(
    parameter int unsigned N      = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  row_stride,
    input  logic [15:0]        num_rows,
    input  logic [N-1:0][15:0] vpu_data_in,
    input  logic [N-1:0]       vpu_valid_in,
    vpu_writeback_if.master    ub,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [15:0]        rows_written
`ifdef VPU_WRITEBACK_CHECKSUM_EN
    ,
    output logic [15:0]        wb_checksum
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StActive, StFinish} state_e;

    state_e state_q, state_d;

    logic [15:0]        mem_q [N][DEPTH];
    logic [N-1:0][PW:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0]  stride_q, next_addr_q, wr_addr_q;
    logic [15:0]        num_rows_q, rows_issued_q, rows_written_q;
    logic [N-1:0][15:0] wr_data_q, head;
    logic               wr_valid_q, overflow_q;

    logic               active, start_ok, row_avail, load, hs, last_hs, drop;
    logic [N-1:0]       lane_empty, lane_full, push, wr_en;

    assign active   = (state_q == StActive);
    assign start_ok = start && (state_q == StIdle);
    assign hs       = wr_valid_q && ub.ub_wr_ready;
    assign last_hs  = active && hs && (rows_written_q == num_rows_q - 16'd1);

    // An empty lane forwards its incoming element straight to the output register.
    always_comb begin
        lane_empty = '0;
        lane_full  = '0;
        head       = '0;
        push       = '0;
        for (int i = 0; i < N; i++) begin
            lane_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            lane_full[i]  = (wr_ptr_q[i][PW] != rd_ptr_q[i][PW]) &&
                            (wr_ptr_q[i][PW-1:0] == rd_ptr_q[i][PW-1:0]);
            head[i]       = lane_empty[i] ? vpu_data_in[i] : mem_q[i][rd_ptr_q[i][PW-1:0]];
            push[i]       = active && vpu_valid_in[i];
        end
    end

    assign row_avail = active && (&(~lane_empty | push)) && (rows_issued_q < num_rows_q);
    assign load      = row_avail && (!wr_valid_q || ub.ub_wr_ready);

    always_comb begin
        wr_en = '0;
        drop  = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr_en[i] = push[i] && !(load && lane_empty[i]) && (!lane_full[i] || load);
            if (push[i] && lane_full[i] && !load) begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_rows == 16'd0) ? StFinish : StActive;
                end
            end
            StActive: begin
                if (last_hs) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StActive);
        done = (state_q == StFinish);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i][PW-1:0]] <= vpu_data_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            stride_q       <= '0;
            next_addr_q    <= '0;
            wr_addr_q      <= '0;
            num_rows_q     <= '0;
            rows_issued_q  <= '0;
            rows_written_q <= '0;
            wr_data_q      <= '0;
            wr_valid_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (start_ok) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            stride_q       <= row_stride;
            next_addr_q    <= base_addr;
            num_rows_q     <= num_rows;
            rows_issued_q  <= '0;
            rows_written_q <= '0;
            overflow_q     <= 1'b0;
        end else if (state_q == StFinish) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (active) begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (load && !lane_empty[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (load) begin
                wr_valid_q    <= 1'b1;
                wr_addr_q     <= next_addr_q;
                wr_data_q     <= head;
                next_addr_q   <= next_addr_q + stride_q;
                rows_issued_q <= rows_issued_q + 16'd1;
            end else if (hs) begin
                wr_valid_q <= 1'b0;
            end
            if (hs) begin
                rows_written_q <= rows_written_q + 16'd1;
            end
        end
    end

    assign ub.ub_wr_valid = wr_valid_q;
    assign ub.ub_wr_addr  = wr_addr_q;
    assign ub.ub_wr_data  = wr_data_q;
    assign overflow       = overflow_q;
    assign rows_written   = rows_written_q;

`ifdef VPU_WRITEBACK_CHECKSUM_EN
    logic [15:0] checksum_q, row_sum;

    always_comb begin
        row_sum = '0;
        for (int i = 0; i < N; i++) begin
            row_sum = row_sum + wr_data_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (hs) begin
            checksum_q <= checksum_q + row_sum;
        end
    end

    assign wb_checksum = checksum_q;
`endif
endmodule

// File: tb/tb_vpu_writeback.sv
// Bench for vpu_writeback: queue-level reference model checked every cycle, directed and
// randomized jobs, plus literal expectations for the basic scenarios.
module tb_vpu_writeback;
    localparam int unsigned N      = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [ADDR_W-1:0]  row_stride = '0;
    logic [15:0]        num_rows = '0;
    logic [N-1:0][15:0] vpu_data_in = '0;
    logic [N-1:0]       vpu_valid_in = '0;
    logic               busy, done, overflow;
    logic [15:0]        rows_written;
`ifdef VPU_WRITEBACK_CHECKSUM_EN
    logic [15:0]        wb_checksum;
`endif

    vpu_writeback_if #(.N(N), .ADDR_W(ADDR_W)) ub ();

    vpu_writeback #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .row_stride   (row_stride),
        .num_rows     (num_rows),
        .vpu_data_in  (vpu_data_in),
        .vpu_valid_in (vpu_valid_in),
        .ub           (ub),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .rows_written (rows_written)
`ifdef VPU_WRITEBACK_CHECKSUM_EN
        ,
        .wb_checksum  (wb_checksum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-lane queues, one output slot, job bookkeeping (0 idle, 1 active, 2 finish).
    int                 m_state;
    logic [15:0]        mq [N][$];
    logic               m_valid, m_ovf;
    logic [ADDR_W-1:0]  m_addr, m_next, m_stride;
    logic [N-1:0][15:0] m_data, m_row;
    logic [15:0]        m_rows, m_issued, m_written;
    logic [ADDR_W-1:0]  log_addr [$];
    logic [N*16-1:0]    log_data [$];
    bit                 m_hs, m_load, m_avail, m_used;
`ifdef VPU_WRITEBACK_CHECKSUM_EN
    logic [15:0]        m_sum;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_valid = 0; m_ovf = 0; m_addr = '0; m_next = '0; m_stride = '0;
            m_data = '0; m_rows = '0; m_issued = '0; m_written = '0;
            for (int i = 0; i < N; i++) mq[i].delete();
`ifdef VPU_WRITEBACK_CHECKSUM_EN
            m_sum = '0;
`endif
        end else begin
            case (m_state)
                0: if (start) begin
                    m_next = base_addr; m_stride = row_stride; m_rows = num_rows;
                    m_issued = '0; m_written = '0; m_ovf = 0;
                    for (int i = 0; i < N; i++) mq[i].delete();
                    log_addr.delete(); log_data.delete();
`ifdef VPU_WRITEBACK_CHECKSUM_EN
                    m_sum = '0;
`endif
                    m_state = (num_rows == 0) ? 2 : 1;
                end
                1: begin
                    m_hs = m_valid && ub.ub_wr_ready;
                    m_avail = (m_issued < m_rows);
                    for (int i = 0; i < N; i++)
                        if (mq[i].size() == 0 && !vpu_valid_in[i]) m_avail = 0;
                    m_load = m_avail && (!m_valid || ub.ub_wr_ready);
                    for (int i = 0; i < N; i++) begin
                        m_used = 0;
                        if (m_load) begin
                            if (mq[i].size() > 0) m_row[i] = mq[i].pop_front();
                            else begin m_row[i] = vpu_data_in[i]; m_used = 1; end
                        end
                        if (vpu_valid_in[i] && !m_used) begin
                            if (mq[i].size() < DEPTH) mq[i].push_back(vpu_data_in[i]);
                            else m_ovf = 1;
                        end
                    end
                    if (m_hs) begin
                        log_addr.push_back(m_addr);
                        log_data.push_back(m_data);
`ifdef VPU_WRITEBACK_CHECKSUM_EN
                        for (int i = 0; i < N; i++) m_sum = m_sum + m_data[i];
`endif
                        m_written = m_written + 16'd1;
                    end
                    if (m_load) begin
                        m_valid = 1; m_addr = m_next; m_data = m_row;
                        m_next = m_next + m_stride; m_issued = m_issued + 16'd1;
                    end else if (m_hs) begin
                        m_valid = 0;
                    end
                    if (m_hs && m_written == m_rows) m_state = 2;
                end
                default: begin
                    for (int i = 0; i < N; i++) mq[i].delete();
                    m_state = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("valid", ub.ub_wr_valid, m_valid);
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("overflow", overflow, m_ovf);
        chk("rows_written", rows_written, m_written);
        if (m_valid) begin
            chk("addr", ub.ub_wr_addr, m_addr);
            chk("data", ub.ub_wr_data, m_data);
        end
`ifdef VPU_WRITEBACK_CHECKSUM_EN
        chk("checksum", wb_checksum, m_sum);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                         input logic rdy);
        vpu_valid_in   = v;
        vpu_data_in[0] = d0;
        vpu_data_in[1] = d1;
        ub.ub_wr_ready = rdy;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [15:0] r);
        start = 1'b1; base_addr = b; row_stride = s; num_rows = r;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin seen = 1; break; end
            tick();
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        ub.ub_wr_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", ub.ub_wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rows", rows_written, 0);
        rst = 1'b0;
        tick();

        // Basic skewed job
        do_start(16'h0010, 16'd2, 16'd3);
        drive(2'b01, 16'd1, 16'd0, 1); tick();
        chk("t1_c1_valid", ub.ub_wr_valid, 0);
        drive(2'b11, 16'd2, 16'd10, 1); tick();
        chk("t1_c2_valid", ub.ub_wr_valid, 1);
        chk("t1_c2_addr", ub.ub_wr_addr, 16'h0010);
        chk("t1_c2_data", ub.ub_wr_data, 32'h000A_0001);
        drive(2'b11, 16'd3, 16'd20, 1); tick();
        drive(2'b10, 16'd0, 16'd30, 1); tick();
        drive(2'b00, 16'd0, 16'd0, 1); tick();
        chk("t1_done", done, 1);
        chk("t1_rows", rows_written, 3);
        chk("t1_ovf", overflow, 0);
        chk("t1_nlog", log_addr.size(), 3);
        chk("t1_a2", log_addr[2], 16'h0014);
        chk("t1_d1", log_data[1], 32'h0014_0002);
        chk("t1_d2", log_data[2], 32'h001E_0003);
        tick();
        chk("t1_done_pulse", done, 0);

        // Backpressure
        do_start(16'h0010, 16'd2, 16'd3);
        drive(2'b01, 16'd1, 16'd0, 0); tick();
        drive(2'b11, 16'd2, 16'd10, 0); tick();
        for (int c = 2; c < 5; c++) begin
            chk("t2_hold_valid", ub.ub_wr_valid, 1);
            chk("t2_hold_addr", ub.ub_wr_addr, 16'h0010);
            chk("t2_hold_data", ub.ub_wr_data, 32'h000A_0001);
            if (c == 2) drive(2'b11, 16'd3, 16'd20, 0);
            else if (c == 3) drive(2'b10, 16'd0, 16'd30, 0);
            else drive(2'b00, 16'd0, 16'd0, 0);
            tick();
        end
        drive(2'b00, 16'd0, 16'd0, 1);
        wait_done(20);
        chk("t2_nlog", log_addr.size(), 3);
        chk("t2_a1", log_addr[1], 16'h0012);
        chk("t2_d2", log_data[2], 32'h001E_0003);
        chk("t2_ovf", overflow, 0);
        tick();

        // Overflow
        do_start(16'h0100, 16'd1, 16'd8);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) chk("t3_no_ovf_yet", overflow, 0);
            drive(2'b11, 16'(k + 1), 16'(100 + k), 0); tick();
        end
        chk("t3_ovf", overflow, 1);
        chk("t3_valid", ub.ub_wr_valid, 1);
        chk("t3_data", ub.ub_wr_data, 32'h0064_0001);
        drive(2'b00, 16'd0, 16'd0, 1);
        for (int k = 0; k < 6; k++) tick();
        chk("t3_drained", rows_written, 5);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 16'(7 + k), 16'(107 + k), 1); tick();
        end
        drive(2'b00, 16'd0, 16'd0, 1);
        wait_done(20);
        chk("t3_rows", rows_written, 8);
        chk("t3_ovf_sticky", overflow, 1);
        chk("t3_d5", log_data[5], 32'h006B_0007);
        tick();
        chk("t3_ovf_idle", overflow, 1);

        // Zero-length job
        do_start(16'h0000, 16'd1, 16'd0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_valid", ub.ub_wr_valid, 0);
        chk("t4_ovf_clr", overflow, 0);
        tick();
        chk("t4_done_pulse", done, 0);
        chk("t4_busy2", busy, 0);

        // Address wrap with an ignored start mid-job
        do_start(16'hFFFE, 16'd1, 16'd3);
        drive(2'b11, 16'd1, 16'd11, 1); tick();
        drive(2'b11, 16'd2, 16'd12, 1);
        start = 1'b1; base_addr = 16'h1234; num_rows = 16'd0;
        tick();
        start = 1'b0;
        drive(2'b11, 16'd3, 16'd13, 1); tick();
        drive(2'b00, 16'd0, 16'd0, 1);
        wait_done(20);
        chk("t5_nlog", log_addr.size(), 3);
        chk("t5_a0", log_addr[0], 16'hFFFE);
        chk("t5_a1", log_addr[1], 16'hFFFF);
        chk("t5_a2", log_addr[2], 16'h0000);
        tick();

        // Reset mid-job
        do_start(16'h0040, 16'd4, 16'd3);
        drive(2'b11, 16'd5, 16'd6, 1); tick();
        drive(2'b11, 16'd7, 16'd8, 1); tick();
        chk("t6_one_row", rows_written, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", ub.ub_wr_valid, 0);
        chk("t6_rst_addr", ub.ub_wr_addr, 0);
        chk("t6_rst_data", ub.ub_wr_data, 0);
        chk("t6_rst_rows", rows_written, 0);
        chk("t6_rst_busy", busy, 0);
        drive(2'b00, 16'd0, 16'd0, 1);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_no_done", done, 0);
        end
        do_start(16'h0080, 16'd1, 16'd2);
        chk("t6_clean_rows", rows_written, 0);
        chk("t6_clean_busy", busy, 1);
        drive(2'b11, 16'd1, 16'd2, 1); tick();
        drive(2'b11, 16'd3, 16'd4, 1); tick();
        drive(2'b00, 16'd0, 16'd0, 1);
        wait_done(20);
        chk("t6_rows", rows_written, 2);
        chk("t6_a0", log_addr[0], 16'h0080);
        tick();

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            do_start(16'($urandom), 16'($urandom_range(0, 5)), 16'($urandom_range(1, 7)));
            for (int c = 0; c < 500; c++) begin
                if (done) break;
                drive(N'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 9) < 7);
                if ($urandom_range(0, 29) == 0) begin
                    start = 1'b1; base_addr = 16'($urandom); num_rows = 16'($urandom_range(0, 3));
                end
                tick();
                start = 1'b0;
            end
            chk("rnd_done", done, 1);
            drive(2'b00, 16'd0, 16'd0, 1);
            tick(); tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vpu_writeback.md
Name: vpu_writeback

Overview:
- Collects the N-lane, column-skewed result stream produced by the VPU and assembles it into aligned rows.
- Writes each row into the unified buffer (UB) through a single ready/valid write port, at programmed addresses.
- Sits between the VPU output and the UB write side. It is the consumer/writer counterpart of the VPU's UB-facing output.
- Per-lane de-skew FIFOs absorb the systolic skew and short UB backpressure. The VPU cannot stall, so any data loss is flagged.

Parameters:
- N, 2, lane count; must match the VPU/systolic array width.
- DEPTH, 4, entries per lane de-skew FIFO; power of two, >= 2.
- ADDR_W, 16, UB address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; latches the job parameters.
- base_addr  in  ADDR_W  UB address of row 0.
- row_stride  in  ADDR_W  address increment per row.
- num_rows  in  16  rows in the job.
- vpu_data_in  in  N x 16 signed  per-lane data from the VPU.
- vpu_valid_in  in  N  per-lane valid from the VPU.
- ub_wr_valid  out  1  write request.
- ub_wr_ready  in  1  UB accepts the write.
- ub_wr_addr  out  ADDR_W  write address.
- ub_wr_data  out  N x 16 signed  row data; lane i goes in slice i.
- busy  out  1  job active.
- done  out  1  one-cycle pulse when the job completes.
- overflow  out  1  sticky; set when a lane element is dropped.
- rows_written  out  16  handshaken row count for the current or last job.

Behaviour:
Reset:
- All outputs 0.
- FIFOs empty, state IDLE.
- Reset mid-job aborts it immediately: no further writes and no done pulse.

States:
- IDLE:
  - vpu_valid_in is ignored; no push, no flag.
  - On start: latch base_addr, row_stride, num_rows. Clear rows_written, overflow and the issue counter. Flush the FIFOs.
  - If num_rows == 0, go to FINISH. Otherwise go to ACTIVE and set busy=1 on the next cycle.
  - start while busy is ignored.
- ACTIVE:
  - Each lane with vpu_valid_in=1 pushes vpu_data_in[i] into FIFO i.
  - A row is available when all N FIFOs are non-empty and rows_issued < num_rows.
- FINISH:
  - Lasts one cycle: done=1, busy=0.
  - FIFOs are flushed. Leftover lane data beyond num_rows is discarded without a flag.
  - Next state is IDLE.

Output register stage:
- Loads when a row is available and (ub_wr_valid==0 or ub_wr_ready==1). Loading pops all N FIFOs simultaneously and increments rows_issued.
- Latency: the last lane of a row is pushed at cycle t; ub_wr_valid is asserted at t+1.
- While ub_wr_valid && !ub_wr_ready, ub_wr_addr and ub_wr_data hold stable.
- On a handshake with no new row to load, ub_wr_valid drops the next cycle.
- Back-to-back handshakes sustain 1 row/cycle.

Addressing and counting:
- The first row is written at base_addr.
- Each loaded row uses the previous address + row_stride, wrapping modulo 2^ADDR_W.
- rows_written increments on each handshake.
- The handshake of row num_rows-1 moves the state to FINISH: done=1 the following cycle.

FIFO boundary cases:
- Push to a full FIFO with a simultaneous pop of that FIFO is legal; there is no loss.
- Push to a full FIFO with no pop drops the element and sets overflow=1. overflow stays set until the next accepted start or reset.
- Lanes never pop individually; the row pop is atomic across all N lanes.

Optional Feature:
- Macro: VPU_WRITEBACK_CHECKSUM_EN.
- Defined:
  - Adds output port wb_checksum (out, 16): the wrapping 16-bit sum of every element of every handshaken row.
  - Cleared on accepted start and on reset.
  - Updated in the cycle after each handshake.
  - Holds its value after done.
- Undefined: the port and the adder are absent. All other behaviour is identical.

Test Plan:
1. Basic skewed job:
   - Stimulus: N=2, start with base=0x0010, stride=2, rows=3. Lane0 valid cycles 0-2 with 1,2,3; lane1 valid cycles 1-3 with 10,20,30; ready=1.
   - Response: writes (0x0010,{1,10}), (0x0012,{2,20}), (0x0014,{3,30}). First ub_wr_valid at cycle 2. done one cycle after the third handshake. rows_written=3, overflow=0.
2. Backpressure:
   - Stimulus: same job, ub_wr_ready=0 for 3 cycles from the first ub_wr_valid.
   - Response: addr 0x0010 and data {1,10} stay stable. All 3 rows are later written in order. overflow=0.
3. Overflow:
   - Stimulus: DEPTH=4, rows=8, ub_wr_ready=0 held, both lanes push 6 aligned elements.
   - Response: the first row sits in the output register and FIFOs hold 4 each. The 6th element per lane is dropped and overflow=1 stays until the next start.
4. Zero-length job:
   - Stimulus: start with rows=0.
   - Response: no ub_wr_valid. done pulses one cycle later; busy stays 0.
5. Address wrap and busy start:
   - Stimulus: base=0xFFFE, stride=1, rows=3; a second start is pulsed mid-job.
   - Response: writes at 0xFFFE, 0xFFFF, 0x0000. The second start is ignored.
6. Reset mid-job:
   - Stimulus: rst asserted after 1 of 3 rows is handshaken.
   - Response: all outputs 0 immediately. No done pulse. A subsequent job starts clean with rows_written=0.
